// File: rtl/cdm_err_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : cdm_err_monitor
//  Description : Error-characterisation stage for the 8x8 carry-disregard
//                approximate multiplier. For each accepted (a, b, r_apx)
//                sample it forms the exact product and the error distance
//                ED = |a*b - r_apx|. Over a window of 2^WIN_LOG2 samples it
//                accumulates a saturating ED sum, the maximum ED and the
//                number of erroneous samples. Results are handed over on a
//                valid/ready handshake.
//  Option      : `define CDM_ERRMON_BIAS_EN adds the signed, saturating
//                bias_sum output (accumulated r_apx - exact).
//  Revision    : 1.0 - initial release
// ============================================================================
module cdm_err_monitor #(
   parameter int WIN_LOG2 = 8,
   parameter int SUM_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [7:0]          a,
   input  logic [7:0]          b,
   input  logic [15:0]         r_apx,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SUM_W-1:0]    sum_ed,
   output logic [15:0]         max_ed,
   output logic [WIN_LOG2:0]   err_cnt,
   output logic                busy
`ifdef CDM_ERRMON_BIAS_EN
   ,
   output logic signed [SUM_W:0] bias_sum
`endif
);

   // Sample index of the final sample in a window (2^WIN_LOG2 - 1).
   localparam logic [WIN_LOG2:0] c_WIN_LAST = {1'b0, {WIN_LOG2{1'b1}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   logic [WIN_LOG2:0]   r_cnt;

   // Pipeline stage 1: raw sample
   logic                r_s1_vld;
   logic [7:0]          r_s1_a;
   logic [7:0]          r_s1_b;
   logic [15:0]         r_s1_r;

   // Pipeline stage 2: error distance
   logic                r_s2_vld;
   logic [15:0]         r_s2_ed;

   logic                w_accept;
   logic                w_start_win;
   logic [15:0]         w_exact;
   logic [15:0]         w_ed;
   logic [SUM_W:0]      w_sum_ext;
   logic [SUM_W-1:0]    w_sum_next;

   // in_ready is a pure decode of the state register.
   assign in_ready    = (r_state == ST_RUN);
   assign w_accept    = in_valid & in_ready;
   assign w_start_win = (r_state == ST_IDLE) & start;

   assign w_exact = {8'b0, r_s1_a} * {8'b0, r_s1_b};
   assign w_ed    = (w_exact >= r_s1_r) ? (w_exact - r_s1_r) : (r_s1_r - w_exact);

   // One extra bit catches the carry out so the sum clamps instead of wrapping.
   assign w_sum_ext  = {1'b0, sum_ed} + {{(SUM_W-15){1'b0}}, r_s2_ed};
   assign w_sum_next = w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];

   // Window control FSM with registered out_valid / busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_RUN;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_accept) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == c_WIN_LAST) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // Stage 2 drains on this same edge, so the stats are final
               // exactly when out_valid rises.
               if (!r_s1_vld) begin
                  r_state   <= ST_DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state   <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Two-stage sample pipeline: capture, then error distance.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_s1_a   <= '0;
         r_s1_b   <= '0;
         r_s1_r   <= '0;
         r_s2_vld <= 1'b0;
         r_s2_ed  <= '0;
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_a <= a;
            r_s1_b <= b;
            r_s1_r <= r_apx;
         end
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_ed <= w_ed;
         end
      end
   end

   // Window statistics: cleared on start, updated when stage 2 holds a sample.
   always_ff @(posedge clk) begin
      if (rst || w_start_win) begin
         sum_ed  <= '0;
         max_ed  <= '0;
         err_cnt <= '0;
      end else if (r_s2_vld) begin
         sum_ed  <= w_sum_next;
         if (r_s2_ed > max_ed) begin
            max_ed <= r_s2_ed;
         end
         err_cnt <= err_cnt + {{WIN_LOG2{1'b0}}, (r_s2_ed != 16'd0)};
      end
   end

`ifdef CDM_ERRMON_BIAS_EN
   logic signed [16:0]      w_bias_diff;
   logic signed [16:0]      r_s2_bias;
   logic signed [SUM_W+1:0] w_bias_ext;

   assign w_bias_diff = $signed({1'b0, r_s1_r}) - $signed({1'b0, w_exact});
   assign w_bias_ext  = $signed({bias_sum[SUM_W], bias_sum})
                      + $signed({{(SUM_W-15){r_s2_bias[16]}}, r_s2_bias});

   // Signed error captured alongside ED in stage 2.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_bias <= '0;
      end else if (r_s1_vld) begin
         r_s2_bias <= w_bias_diff;
      end
   end

   // Signed bias accumulator; top two bits differing flags overflow.
   always_ff @(posedge clk) begin
      if (rst || w_start_win) begin
         bias_sum <= '0;
      end else if (r_s2_vld) begin
         if (w_bias_ext[SUM_W+1] != w_bias_ext[SUM_W]) begin
            bias_sum <= w_bias_ext[SUM_W+1] ? {1'b1, {SUM_W{1'b0}}}
                                            : {1'b0, {SUM_W{1'b1}}};
         end else begin
            bias_sum <= w_bias_ext[SUM_W:0];
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdm_err_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdm_err_monitor
//  Description : Directed self-checking bench for cdm_err_monitor. Three
//                instances: WIN_LOG2=2 (general), WIN_LOG2=3/SUM_W=16
//                (saturation), default WIN_LOG2=8 (long random window).
//  Option      : honours `define CDM_ERRMON_BIAS_EN (checks bias_sum).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdm_err_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_w2 = 1'b0, start_sat = 1'b0, start_w8 = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  a = '0, b = '0;
   logic [15:0] r_apx = '0;
   logic        out_ready = 1'b0;

   logic        ir_w2, ir_sat, ir_w8;
   logic        ov_w2, ov_sat, ov_w8;
   logic        bz_w2, bz_sat, bz_w8;
   logic [31:0] sum_w2, sum_w8;
   logic [15:0] sum_sat;
   logic [15:0] max_w2, max_sat, max_w8;
   logic [2:0]  err_w2;
   logic [3:0]  err_sat;
   logic [8:0]  err_w8;
`ifdef CDM_ERRMON_BIAS_EN
   logic signed [32:0] bias_w2, bias_w8;
   logic signed [16:0] bias_sat;
`endif

   int errors = 0;
   int checks = 0;
   int sel    = 0;

   logic        mon_ir, mon_ov, mon_bz;
   logic [31:0] mon_sum;
   logic [15:0] mon_max;
   logic [8:0]  mon_err;

   always #5 clk = ~clk;

   cdm_err_monitor #(.WIN_LOG2(2), .SUM_W(32)) u_w2 (
      .clk(clk), .rst(rst), .start(start_w2), .in_valid(in_valid), .in_ready(ir_w2),
      .a(a), .b(b), .r_apx(r_apx), .out_valid(ov_w2), .out_ready(out_ready),
      .sum_ed(sum_w2), .max_ed(max_w2), .err_cnt(err_w2), .busy(bz_w2)
`ifdef CDM_ERRMON_BIAS_EN
      , .bias_sum(bias_w2)
`endif
   );

   cdm_err_monitor #(.WIN_LOG2(3), .SUM_W(16)) u_sat (
      .clk(clk), .rst(rst), .start(start_sat), .in_valid(in_valid), .in_ready(ir_sat),
      .a(a), .b(b), .r_apx(r_apx), .out_valid(ov_sat), .out_ready(out_ready),
      .sum_ed(sum_sat), .max_ed(max_sat), .err_cnt(err_sat), .busy(bz_sat)
`ifdef CDM_ERRMON_BIAS_EN
      , .bias_sum(bias_sat)
`endif
   );

   cdm_err_monitor #(.WIN_LOG2(8), .SUM_W(32)) u_w8 (
      .clk(clk), .rst(rst), .start(start_w8), .in_valid(in_valid), .in_ready(ir_w8),
      .a(a), .b(b), .r_apx(r_apx), .out_valid(ov_w8), .out_ready(out_ready),
      .sum_ed(sum_w8), .max_ed(max_w8), .err_cnt(err_w8), .busy(bz_w8)
`ifdef CDM_ERRMON_BIAS_EN
      , .bias_sum(bias_w8)
`endif
   );

   // Observe the instance currently under test.
   always_comb begin
      mon_ir = ir_w2; mon_ov = ov_w2; mon_bz = bz_w2;
      mon_sum = sum_w2; mon_max = max_w2; mon_err = 9'(err_w2);
      if (sel == 1) begin
         mon_ir = ir_sat; mon_ov = ov_sat; mon_bz = bz_sat;
         mon_sum = 32'(sum_sat); mon_max = max_sat; mon_err = 9'(err_sat);
      end else if (sel == 2) begin
         mon_ir = ir_w8; mon_ov = ov_w8; mon_bz = bz_w8;
         mon_sum = sum_w8; mon_max = max_w8; mon_err = err_w8;
      end
   end

   // Carry-disregard approximation: low-column carries are dropped (XOR).
   function automatic logic [15:0] cdm_approx(input logic [7:0] x, input logic [7:0] y);
      logic [15:0] hi;
      logic [7:0]  lo;
      hi = '0;
      lo = '0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if (x[i] & y[j]) begin
               if (i + j < 8) lo[i+j] = ~lo[i+j];
               else           hi = hi + (16'd1 << (i + j));
            end
      return hi | {8'b0, lo};
   endfunction

   task automatic pulse_start(input int which);
      if (which == 0) start_w2 = 1'b1;
      else if (which == 1) start_sat = 1'b1;
      else start_w8 = 1'b1;
      @(negedge clk);
      start_w2 = 1'b0; start_sat = 1'b0; start_w8 = 1'b0;
   endtask

   task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic [15:0] rr);
      in_valid = 1'b1; a = aa; b = bb; r_apx = rr;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic send_mixed();
      send(8'd10, 8'd10, 16'd104);   // ED 4,   bias +4
      send(8'd2,  8'd3,  16'd6);     // ED 0
      send(8'd20, 8'd20, 16'd300);   // ED 100, bias -100
      send(8'd7,  8'd8,  16'd68);    // ED 12,  bias +12
   endtask

   task automatic test_reset();
      sel = 0;
      rst = 1'b1; start_w2 = 1'b1;
      @(negedge clk); @(negedge clk);
      rst = 1'b0; start_w2 = 1'b0;
      checks++; if (mon_ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", mon_ov); end
      checks++; if (mon_bz !== 1'b0) begin errors++; $display("FAIL reset_busy (start with rst): got %b expected 0", mon_bz); end
      checks++; if (mon_ir !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", mon_ir); end
      checks++; if (mon_sum !== 32'd0 || mon_max !== 16'd0 || mon_err !== 9'd0) begin
         errors++; $display("FAIL reset_stats: got sum=%0d max=%0d err=%0d expected 0/0/0", mon_sum, mon_max, mon_err); end
      checks++; if (ov_sat !== 1'b0 || ov_w8 !== 1'b0 || bz_sat !== 1'b0 || bz_w8 !== 1'b0) begin
         errors++; $display("FAIL reset_other_inst: got ov=%b%b busy=%b%b expected 0", ov_sat, ov_w8, bz_sat, bz_w8); end
      @(negedge clk);
      checks++; if (mon_bz !== 1'b0) begin errors++; $display("FAIL reset_start_not_latched: got busy=%b expected 0", mon_bz); end
   endtask

   task automatic test_exact_window();
      sel = 0;
      pulse_start(0);
      checks++; if (mon_ir !== 1'b1 || mon_bz !== 1'b1) begin
         errors++; $display("FAIL exact_run_entry: got in_ready=%b busy=%b expected 1/1", mon_ir, mon_bz); end
      send(8'd3, 8'd5, 16'd15);
      send(8'd255, 8'd255, 16'd65025);
      send(8'd0, 8'd7, 16'd0);
      send(8'd16, 8'd16, 16'd256);
      checks++; if (mon_ir !== 1'b0 || mon_ov !== 1'b0 || mon_bz !== 1'b1) begin
         errors++; $display("FAIL exact_drain_entry: got in_ready=%b out_valid=%b busy=%b expected 0/0/1", mon_ir, mon_ov, mon_bz); end
      @(negedge clk);
      checks++; if (mon_ov !== 1'b0) begin errors++; $display("FAIL exact_latency_early: got out_valid=%b expected 0", mon_ov); end
      @(negedge clk);
      checks++; if (mon_ov !== 1'b1 || mon_bz !== 1'b0) begin
         errors++; $display("FAIL exact_latency: got out_valid=%b busy=%b expected 1/0", mon_ov, mon_bz); end
      checks++; if (mon_sum !== 32'd0 || mon_max !== 16'd0 || mon_err !== 9'd0) begin
         errors++; $display("FAIL exact_stats: got sum=%0d max=%0d err=%0d expected 0/0/0", mon_sum, mon_max, mon_err); end
      handshake();
      checks++; if (mon_ov !== 1'b0) begin errors++; $display("FAIL exact_handshake: got out_valid=%b expected 0", mon_ov); end
   endtask

   task automatic test_mixed_ed();
      sel = 0;
      pulse_start(0);
      send_mixed();
      for (int k = 0; k < 8 && mon_ov !== 1'b1; k++) @(negedge clk);
      checks++; if (mon_ov !== 1'b1) begin errors++; $display("FAIL mixed_timeout: got out_valid=%b expected 1", mon_ov); end
      checks++; if (mon_sum !== 32'd116) begin errors++; $display("FAIL mixed_sum: got %0d expected 116", mon_sum); end
      checks++; if (mon_max !== 16'd100) begin errors++; $display("FAIL mixed_max: got %0d expected 100", mon_max); end
      checks++; if (mon_err !== 9'd3) begin errors++; $display("FAIL mixed_err: got %0d expected 3", mon_err); end
`ifdef CDM_ERRMON_BIAS_EN
      checks++; if (bias_w2 !== -33'sd84) begin errors++; $display("FAIL mixed_bias: got %0d expected -84", bias_w2); end
`endif
   endtask

   task automatic test_hold_done();
      logic bad;
      sel = 0;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         start_w2 = (i == 4);
         @(negedge clk);
         if (mon_ov !== 1'b1 || mon_ir !== 1'b0 || mon_bz !== 1'b0 ||
             mon_sum !== 32'd116 || mon_max !== 16'd100 || mon_err !== 9'd3) bad = 1'b1;
      end
      start_w2 = 1'b0;
      checks++; if (bad !== 1'b0) begin
         errors++; $display("FAIL hold_stable: got ov=%b ir=%b sum=%0d max=%0d err=%0d expected 1/0/116/100/3", mon_ov, mon_ir, mon_sum, mon_max, mon_err); end
      handshake();
      checks++; if (mon_ov !== 1'b0 || mon_bz !== 1'b0) begin
         errors++; $display("FAIL hold_release: got out_valid=%b busy=%b expected 0/0", mon_ov, mon_bz); end
      checks++; if (mon_sum !== 32'd116) begin errors++; $display("FAIL hold_result_kept: got %0d expected 116", mon_sum); end
      pulse_start(0);
      checks++; if (mon_sum !== 32'd0 || mon_max !== 16'd0 || mon_err !== 9'd0 || mon_bz !== 1'b1) begin
         errors++; $display("FAIL hold_start_clears: got sum=%0d max=%0d err=%0d busy=%b expected 0/0/0/1", mon_sum, mon_max, mon_err, mon_bz); end
   endtask

   task automatic test_reset_mid();
      logic seen;
      sel = 0;
      send(8'd20, 8'd20, 16'd300);
      send(8'd10, 8'd10, 16'd104);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (mon_ov !== 1'b0 || mon_bz !== 1'b0 || mon_ir !== 1'b0 ||
                    mon_sum !== 32'd0 || mon_max !== 16'd0 || mon_err !== 9'd0) begin
         errors++; $display("FAIL midrst_clear: got ov=%b busy=%b ir=%b sum=%0d max=%0d err=%0d expected all 0", mon_ov, mon_bz, mon_ir, mon_sum, mon_max, mon_err); end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mon_ov !== 1'b0 || mon_sum !== 32'd0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_valid: got out_valid/sum activity=%b expected 0", seen); end
      pulse_start(0);
      send_mixed();
      for (int k = 0; k < 8 && mon_ov !== 1'b1; k++) @(negedge clk);
      checks++; if (mon_ov !== 1'b1 || mon_sum !== 32'd116 || mon_max !== 16'd100 || mon_err !== 9'd3) begin
         errors++; $display("FAIL midrst_fresh: got ov=%b sum=%0d max=%0d err=%0d expected 1/116/100/3", mon_ov, mon_sum, mon_max, mon_err); end
      handshake();
   endtask

   task automatic test_saturation();
      sel = 1;
      pulse_start(1);
      for (int i = 0; i < 8; i++) send(8'd200, 8'd200, 16'd20000);
      for (int k = 0; k < 8 && mon_ov !== 1'b1; k++) @(negedge clk);
      checks++; if (mon_ov !== 1'b1) begin errors++; $display("FAIL sat_timeout: got out_valid=%b expected 1", mon_ov); end
      checks++; if (mon_sum !== 32'd65535) begin errors++; $display("FAIL sat_sum: got %0d expected 65535", mon_sum); end
      checks++; if (mon_max !== 16'd20000) begin errors++; $display("FAIL sat_max: got %0d expected 20000", mon_max); end
      checks++; if (mon_err !== 9'd8) begin errors++; $display("FAIL sat_err_full: got %0d expected 8", mon_err); end
`ifdef CDM_ERRMON_BIAS_EN
      checks++; if (bias_sat !== 17'h10000) begin errors++; $display("FAIL sat_bias: got %0d expected -65536", bias_sat); end
`endif
      handshake();
   endtask

   task automatic test_back_to_back_random();
      longint m_sum, m_bias;
      int     m_max, m_err, ex, ed, sent, ir_bad;
      logic [7:0]  ra, rb;
      logic [15:0] rr;
      sel = 2;
      m_sum = 0; m_bias = 0; m_max = 0; m_err = 0; sent = 0; ir_bad = 0;
      pulse_start(2);
      for (int cyc = 0; cyc < 4000 && sent < 256; cyc++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rr = cdm_approx(ra, rb);
         a = ra; b = rb; r_apx = rr;
         if ($urandom_range(0, 1) == 1) begin
            in_valid = 1'b1;
            checks++; if (mon_ir !== 1'b1) begin errors++; ir_bad++; $display("FAIL rand_in_ready: sample %0d got %b expected 1", sent, mon_ir); end
            ex = int'(ra) * int'(rb);
            ed = (ex >= int'(rr)) ? ex - int'(rr) : int'(rr) - ex;
            m_sum  += ed;
            m_bias += longint'(int'(rr) - ex);
            if (ed > m_max) m_max = ed;
            if (ed != 0) m_err++;
            sent++;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++; if (mon_ir !== 1'b0) begin errors++; $display("FAIL rand_window_len: got in_ready=%b after 256 accepts expected 0", mon_ir); end
      for (int k = 0; k < 8 && mon_ov !== 1'b1; k++) @(negedge clk);
      checks++; if (mon_ov !== 1'b1) begin errors++; $display("FAIL rand_timeout: got out_valid=%b expected 1", mon_ov); end
      checks++; if (mon_sum !== 32'(m_sum)) begin errors++; $display("FAIL rand_sum: got %0d expected %0d", mon_sum, m_sum); end
      checks++; if (mon_max !== 16'(m_max)) begin errors++; $display("FAIL rand_max: got %0d expected %0d", mon_max, m_max); end
      checks++; if (mon_err !== 9'(m_err)) begin errors++; $display("FAIL rand_err: got %0d expected %0d", mon_err, m_err); end
`ifdef CDM_ERRMON_BIAS_EN
      checks++; if (bias_w8 !== 33'(m_bias)) begin errors++; $display("FAIL rand_bias: got %0d expected %0d", bias_w8, m_bias); end
`endif
      handshake();
   endtask

   initial begin
      test_reset();
      test_exact_window();
      test_mixed_ed();
      test_hold_done();
      test_reset_mid();
      test_saturation();
      test_back_to_back_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
